dm_access_unit: RTL and testbench
=================================

// Module: dm_access_unit
// PURPOSE
//  Data-memory responder for the load/store control codes DMWr/DMRe that the control unit emits.
//  Accepts one request at a time over a valid/ready handshake, then checks alignment and range.
//  Drives byte-lane write enables into a synchronous RAM, and sign/zero-extends load data.
//  Returns a single-cycle response pulse.
//  Sits between the pipeline memory stage and the data RAM. The stage stalls while req_ready=0.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the data RAM (power of two)
//  BASE_ADDR    32'h0 byte address mapped to RAM word 0
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   unit can accept; high only in IDLE
//  DMWr       in   2   store code: DMWR_NOP/SB/SH/SW
//  DMRe       in   3   load code: DMRE_NOP/LB/LBU/LH/LHU/LW
//  addr       in   32  byte address (ALU result)
//  wdata      in   32  store data (rt); low byte/half used for SB/SH
//  rsp_valid  out  1   one-cycle pulse: access complete
//  rdata      out  32  extended load data; 0 for stores and errors
//  err        out  1   with rsp_valid: misaligned, out-of-range or illegal code
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rdata=0, err=0, state=IDLE; RAM contents not cleared.
//  Handshake: a request is accepted on a clock edge where req_valid&req_ready.
//   Inputs are sampled only at acceptance.
//  Accepted request with both codes NOP: completes as a store with no write (rsp_valid, err=0).
//  FSM states: IDLE, READ, RESP.
//   IDLE  -> RESP  on accept of a store, NOP or error request.
//            A legal store writes RAM on this same edge.
//   IDLE  -> READ  on accept of a legal load; RAM read is issued.
//   READ  -> RESP  unconditionally. RAM data is formatted and registered into rdata.
//   RESP  -> IDLE  unconditionally. rsp_valid=1 for exactly this cycle.
//  Latency from accept edge to rsp_valid: store 1 cycle, load 2 cycles.
//   Next accept is possible in the cycle rsp_valid is high? No: the earliest next accept is
//   the cycle after RESP.
//  Byte order is little-endian: lane k = addr[1:0]=k = bits [8k+7:8k].
//   SB: lane addr[1:0].
//   SH: lanes {addr[1],0} and {addr[1],1}.
//   SW: all four lanes.
//   wdata is replicated to the selected lanes.
//  Loads:
//   LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
//   Lane select uses the latched addr[1:0].
//  Error cases (err=1, no RAM write, rdata=0, response still through RESP):
//   - LH/LHU/SH with addr[0]=1
//   - LW/SW with addr[1:0]!=0
//   - (addr-BASE_ADDR)>>2 >= DEPTH_WORDS, using 32-bit unsigned wrap-around arithmetic
//   - DMWr!=NOP and DMRe!=NOP simultaneously
//   - unused DMRe encodings
//  Reset asserted in READ or RESP: return to IDLE and drop the pending response.
//   A write committed on an earlier edge stays in RAM.
//  rsp_valid and err are registered outputs. rdata holds its value until the next response.
// STRUCTURE
//  Shared package ctrl_encode_def.v holds:
//   - DMWR_* / DMRE_* codes
//   - new DMAU_IDLE/READ/RESP state constants
//  Sub-module dm_ram: DEPTH_WORDS x 32 synchronous RAM with a 4-bit byte write enable
//   and a 1-cycle registered read.
//  Top level holds the FSM, the request latch, lane/extend logic and error checks.
// TESTING
//  1) SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> rsp 1 cycle after the store.
//     Load rsp 2 cycles after accept: rdata=0xDEADBEEF, err=0.
//  2) SB 0x13 wdata=0x80, then LB 0x13 -> rdata=0xFFFFFF80. Same address with LBU -> 0x00000080.
//  3) SH 0x16 wdata=0x0000_8001, then LH 0x16 -> 0xFFFF8001. LHU -> 0x00008001.
//     The lower half of word 0x14 is unchanged.
//  4) LW 0x12 -> err=1, rdata=0. SH 0x11 -> err=1 and RAM word unchanged.
//     Addr DEPTH_WORDS*4 -> err=1.
//  5) Assert rst in READ -> next cycle: state IDLE, req_ready=1, no rsp_valid pulse.
//     Earlier SW data is retained.
//  6) req_valid held high back-to-back -> req_ready low in READ/RESP.
//     Exactly one rsp_valid per accepted request, issued in order.

Source files
------------

// File: rtl/ctrl_encode_def.sv
// Shared control encodings for the data-memory path: store/load codes, the
// access-unit state type, and the load lane-select/extend helper.
package ctrl_encode_def;

  typedef enum logic [1:0] {
    DMWR_NOP = 2'b00,
    DMWR_SB  = 2'b01,
    DMWR_SH  = 2'b10,
    DMWR_SW  = 2'b11
  } dmwr_e;

  // Encodings 3'b110 and 3'b111 are unused and reported as errors.
  typedef enum logic [2:0] {
    DMRE_NOP = 3'b000,
    DMRE_LB  = 3'b001,
    DMRE_LBU = 3'b010,
    DMRE_LH  = 3'b011,
    DMRE_LHU = 3'b100,
    DMRE_LW  = 3'b101
  } dmre_e;

  typedef enum logic [1:0] {
    DMAU_IDLE = 2'b00,
    DMAU_READ = 2'b01,
    DMAU_RESP = 2'b10
  } dmau_state_e;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] dm_load_extend(input logic [2:0]  code,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (code)
      DMRE_LB:  return {{24{b[7]}}, b};
      DMRE_LBU: return {24'h0, b};
      DMRE_LH:  return {{16{h[15]}}, h};
      DMRE_LHU: return {16'h0, h};
      DMRE_LW:  return word;
      default:  return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_ram.sv
// Word-organised synchronous data RAM with per-byte write enables and a
// one-cycle registered read port.
module dm_access_unit_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // NOTE: the array has no reset on purpose -- clearing it would turn the
  // RAM into flops; contents are undefined until written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_be[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
    end
    if (i_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory responder: accepts one load/store at a time, validates it,
// drives the byte-lane RAM and returns a one-cycle response pulse.
module dm_access_unit
  import ctrl_encode_def::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  DMWr,
  input  logic [2:0]  DMRe,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmau_state_e     r_state, w_next_state;
  logic            w_accept, w_is_store, w_is_load;
  logic            w_illegal, w_misaligned, w_out_of_range, w_req_err;
  logic            w_ram_en;
  logic [3:0]      w_be;
  logic [31:0]     w_offset, w_ram_wdata, w_ram_rdata;
  logic [AW-1:0]   w_word_idx;
  logic [2:0]      r_dmre;
  logic [1:0]      r_lane;
  logic            r_rsp_valid, r_err;
  logic [31:0]     r_rdata;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_is_store = (DMWr != DMWR_NOP);
    w_is_load  = (DMRe != DMRE_NOP);
    w_illegal  = (w_is_store && w_is_load) || (DMRe > 3'(DMRE_LW));

    w_misaligned = 1'b0;
    if (DMRe == DMRE_LH || DMRe == DMRE_LHU || DMWr == DMWR_SH)
      w_misaligned = addr[0];
    if (DMRe == DMRE_LW || DMWr == DMWR_SW)
      w_misaligned = w_misaligned | (addr[1:0] != 2'b00);

    // Wrap-around subtraction maps addresses below BASE_ADDR out of range too.
    w_offset       = addr - BASE_ADDR;
    w_out_of_range = (w_is_store || w_is_load) &&
                     ((w_offset >> 2) >= 32'(DEPTH_WORDS));
    w_req_err      = w_illegal || w_misaligned || w_out_of_range;
    w_word_idx     = w_offset[AW+1:2];

    w_accept = req_valid && req_ready;
    w_ram_en = w_accept && !w_req_err && (w_is_store || w_is_load);

    w_be        = 4'b0000;
    w_ram_wdata = wdata;
    if (w_ram_en) begin
      case (DMWr)
        DMWR_SB: begin
          w_be        = 4'b0001 << addr[1:0];
          w_ram_wdata = {4{wdata[7:0]}};
        end
        DMWR_SH: begin
          w_be        = addr[1] ? 4'b1100 : 4'b0011;
          w_ram_wdata = {2{wdata[15:0]}};
        end
        DMWR_SW: w_be = 4'b1111;
        default: w_be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = (r_state == DMAU_IDLE);
    case (r_state)
      DMAU_IDLE: if (w_accept)
                   w_next_state = (w_is_load && !w_req_err) ? DMAU_READ : DMAU_RESP;
      DMAU_READ: w_next_state = DMAU_RESP;
      DMAU_RESP: w_next_state = DMAU_IDLE;
      default:   w_next_state = DMAU_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= DMAU_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_dmre      <= DMRE_NOP;
      r_lane      <= 2'b00;
    end else begin
      r_rsp_valid <= (w_next_state == DMAU_RESP);
      r_err       <= 1'b0;
      if (w_accept) begin
        r_dmre <= DMRe;
        r_lane <= addr[1:0];
        if (w_next_state == DMAU_RESP) begin
          r_rdata <= 32'h0;
          r_err   <= w_req_err;
        end
      end
      if (r_state == DMAU_READ) r_rdata <= dm_load_extend(r_dmre, r_lane, w_ram_rdata);
    end
  end

  dm_access_unit_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_be    (w_be),
    .i_addr  (w_word_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign rsp_valid = r_rsp_valid;
  assign rdata     = r_rdata;
  assign err       = r_err;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: stores, extended loads, error cases,
// mid-access reset and back-to-back requests, all against hand-computed values.
module tb_dm_access_unit;
  import ctrl_encode_def::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  DMWr = DMWR_NOP;
  logic [2:0]  DMRe = DMRE_NOP;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  dm_access_unit #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .DMWr      (DMWr),
    .DMRe      (DMRe),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Issue one request and wait for its response; returns sampled outputs and latency.
  task automatic do_req(input logic [1:0] wr, input logic [2:0] re,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got_rd, output logic got_err,
                        output int lat);
    int w = 0;
    while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
    DMWr = wr; DMRe = re; addr = a; wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; DMWr = DMWR_NOP; DMRe = DMRE_NOP;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    got_rd  = rdata;
    got_err = err;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout addr=%h got rsp_valid=%b exp 1", a, rsp_valid);
    end
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] got_rd, input logic got_err,
                            input logic [31:0] exp_rd, input logic exp_err);
    checks++;
    if (got_rd !== exp_rd || got_err !== exp_err) begin
      errors++;
      $display("FAIL %s got rdata=%h err=%b exp rdata=%h err=%b",
               name, got_rd, got_err, exp_rd, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, err} !== 3'b100 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset got ready=%b rsp=%b err=%b rdata=%h exp 1 0 0 0",
               req_ready, rsp_valid, err, rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    do_req(DMWR_SW, DMRE_NOP, 32'h10, 32'hDEADBEEF, rd, e, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sw_latency got=%0d exp=1", lat); end
    expect_rsp("sw_rsp", rd, e, 32'h0, 1'b0);
    do_req(DMWR_NOP, DMRE_LW, 32'h10, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    expect_rsp("lw_10", rd, e, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    do_req(DMWR_SB, DMRE_NOP, 32'h13, 32'h00000080, rd, e, lat);
    expect_rsp("sb_13", rd, e, 32'h0, 1'b0);
    do_req(DMWR_NOP, DMRE_LB, 32'h13, 32'h0, rd, e, lat);
    expect_rsp("lb_13", rd, e, 32'hFFFFFF80, 1'b0);
    do_req(DMWR_NOP, DMRE_LBU, 32'h13, 32'h0, rd, e, lat);
    expect_rsp("lbu_13", rd, e, 32'h00000080, 1'b0);
    do_req(DMWR_NOP, DMRE_LW, 32'h10, 32'h0, rd, e, lat);
    expect_rsp("lw_after_sb", rd, e, 32'h80ADBEEF, 1'b0);
  endtask

  task automatic test_half();
    logic [31:0] rd; logic e; int lat;
    do_req(DMWR_SW, DMRE_NOP, 32'h14, 32'h11223344, rd, e, lat);
    do_req(DMWR_SH, DMRE_NOP, 32'h16, 32'h00008001, rd, e, lat);
    expect_rsp("sh_16", rd, e, 32'h0, 1'b0);
    do_req(DMWR_NOP, DMRE_LH, 32'h16, 32'h0, rd, e, lat);
    expect_rsp("lh_16", rd, e, 32'hFFFF8001, 1'b0);
    do_req(DMWR_NOP, DMRE_LHU, 32'h16, 32'h0, rd, e, lat);
    expect_rsp("lhu_16", rd, e, 32'h00008001, 1'b0);
    do_req(DMWR_NOP, DMRE_LH, 32'h14, 32'h0, rd, e, lat);
    expect_rsp("lh_14_lower_kept", rd, e, 32'h00003344, 1'b0);
    do_req(DMWR_NOP, DMRE_LW, 32'h14, 32'h0, rd, e, lat);
    expect_rsp("lw_14", rd, e, 32'h80013344, 1'b0);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    do_req(DMWR_NOP, DMRE_LW, 32'h12, 32'h0, rd, e, lat);
    expect_rsp("lw_misaligned", rd, e, 32'h0, 1'b1);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL err_latency got=%0d exp=1", lat); end
    do_req(DMWR_SH, DMRE_NOP, 32'h11, 32'h0000FFFF, rd, e, lat);
    expect_rsp("sh_misaligned", rd, e, 32'h0, 1'b1);
    do_req(DMWR_NOP, DMRE_LW, 32'h10, 32'h0, rd, e, lat);
    expect_rsp("word_10_unchanged", rd, e, 32'h80ADBEEF, 1'b0);
    do_req(DMWR_SW, DMRE_NOP, 32'h1000, 32'h12345678, rd, e, lat);
    expect_rsp("sw_out_of_range", rd, e, 32'h0, 1'b1);
    do_req(DMWR_NOP, DMRE_LB, 32'h1000, 32'h0, rd, e, lat);
    expect_rsp("lb_out_of_range", rd, e, 32'h0, 1'b1);
    do_req(DMWR_SW, DMRE_NOP, 32'hFFC, 32'h55AA55AA, rd, e, lat);
    do_req(DMWR_NOP, DMRE_LW, 32'hFFC, 32'h0, rd, e, lat);
    expect_rsp("lw_last_word", rd, e, 32'h55AA55AA, 1'b0);
    do_req(DMWR_SW, DMRE_LW, 32'h20, 32'h0, rd, e, lat);
    expect_rsp("both_codes", rd, e, 32'h0, 1'b1);
    do_req(DMWR_NOP, 3'b110, 32'h20, 32'h0, rd, e, lat);
    expect_rsp("illegal_dmre", rd, e, 32'h0, 1'b1);
    do_req(DMWR_NOP, DMRE_NOP, 32'h20, 32'h0, rd, e, lat);
    expect_rsp("nop", rd, e, 32'h0, 1'b0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL nop_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; int pulses = 0;
    do_req(DMWR_SW, DMRE_NOP, 32'h20, 32'hCAFEF00D, rd, e, lat);
    @(posedge clk); #1;
    DMRe = DMRE_LW; addr = 32'h20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; DMRe = DMRE_NOP;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_in_read got=%b exp=0", req_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_read got ready=%b rsp=%b exp 1 0", req_ready, rsp_valid);
    end
    repeat (3) begin @(posedge clk); #1; if (rsp_valid) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL dropped_rsp got pulses=%0d exp=0", pulses); end
    do_req(DMWR_NOP, DMRE_LW, 32'h20, 32'h0, rd, e, lat);
    expect_rsp("retained_after_reset", rd, e, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  wr [5];
    logic [2:0]  re [5];
    logic [31:0] ad [5], wd [5], exp_rd [5];
    int n_acc = 0, n_rsp = 0, ready_bad = 0;
    logic busy = 1'b0, done = 1'b0, rdy;
    wr = '{DMWR_SW, DMWR_NOP, DMWR_SB, DMWR_NOP, DMWR_NOP};
    re = '{DMRE_NOP, DMRE_LW, DMRE_NOP, DMRE_LBU, DMRE_LW};
    ad = '{32'h40, 32'h40, 32'h41, 32'h41, 32'h40};
    wd = '{32'h01020304, 32'h0, 32'h000000AA, 32'h0, 32'h0};
    exp_rd = '{32'h0, 32'h01020304, 32'h0, 32'h000000AA, 32'h0102AA04};
    @(posedge clk); #1;
    DMWr = wr[0]; DMRe = re[0]; addr = ad[0]; wdata = wd[0]; req_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && n_rsp < 5; cyc++) begin
      @(negedge clk);
      rdy = req_ready;
      if (rdy !== !busy) ready_bad++;
      if (done) begin busy = 1'b0; done = 1'b0; end
      @(posedge clk); #1;
      if (rdy && req_valid) begin
        n_acc++;
        busy = 1'b1;
        if (n_acc < 5) begin
          DMWr = wr[n_acc]; DMRe = re[n_acc]; addr = ad[n_acc]; wdata = wd[n_acc];
        end else begin
          req_valid = 1'b0; DMWr = DMWR_NOP; DMRe = DMRE_NOP;
        end
      end
      if (rsp_valid) begin
        checks++;
        if (n_rsp >= 5 || rdata !== exp_rd[n_rsp] || err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rsp%0d got rdata=%h err=%b exp rdata=%h err=0",
                   n_rsp, rdata, err, exp_rd[n_rsp < 5 ? n_rsp : 4]);
        end
        n_rsp++;
        done = 1'b1;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (ready_bad !== 0) begin errors++; $display("FAIL b2b_ready got bad=%0d exp=0", ready_bad); end
    checks++;
    if (n_acc !== 5 || n_rsp !== 5) begin
      errors++;
      $display("FAIL b2b_count got acc=%0d rsp=%0d exp 5 5", n_acc, n_rsp);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
